axi_inter_wr_arb: RTL

- Write-path arbiter for one slave port of the AXI4 interconnect.
- Picks one of 2**SEL_WIDTH masters round-robin and drives the select code for the master→slave AW/W multiplexer and the slave→master B demultiplexer.
- Holds the grant for one full write transaction: AW, W burst through WLAST, then B.
- Generates per-channel enables that gate valid/ready through the selectors.

---
 rtl/axi_inter_pkg.sv | 20 ++
 rtl/axi_inter_rr_pick.sv | 41 ++++
 rtl/axi_inter_wr_arb.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/axi_inter_pkg.sv
// ---------------------------------------------------------------------------
// axi_inter_pkg
// Shared types and helpers for the AXI4 interconnect arbiters.
//   wr_arb_state_t : write-arbiter FSM encoding (IDLE / DATA / RESP)
//   n_masters()    : number of masters addressed by a select code width
// ---------------------------------------------------------------------------
package axi_inter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } wr_arb_state_t;

    // A select code of sel_width bits addresses 2**sel_width masters.
    function automatic int n_masters(input int sel_width);
        return 1 << sel_width;
    endfunction

endpackage : axi_inter_pkg

// File: rtl/axi_inter_rr_pick.sv
// ---------------------------------------------------------------------------
// axi_inter_rr_pick
// Combinational round-robin picker shared by the read and write arbiters.
// Searches req upward starting at ptr, wrapping modulo N_M, and reports the
// first set bit.
//   req   [N_M]       : request vector
//   ptr   [SEL_WIDTH] : highest-priority index for this search
//   idx   [SEL_WIDTH] : winning index (0 when nothing is requested)
//   found             : at least one request is set
// ---------------------------------------------------------------------------
module axi_inter_rr_pick
    import axi_inter_pkg::*;
#(
    parameter  int SEL_WIDTH = 2,
    localparam int N_M       = n_masters(SEL_WIDTH)
) (
    input  logic [N_M-1:0]       req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic [SEL_WIDTH-1:0] idx,
    output logic                 found
);

    logic [SEL_WIDTH-1:0] cand;

    // NOTE: every signal written in always_comb gets a default before any
    // conditional assignment; otherwise a latch is inferred.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_M; i++) begin
            // SEL_WIDTH-bit addition wraps modulo N_M for free.
            cand = ptr + SEL_WIDTH'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule : axi_inter_rr_pick

// File: rtl/axi_inter_wr_arb.sv
// ---------------------------------------------------------------------------
// axi_inter_wr_arb
// Write-path arbiter for one slave port of the AXI4 interconnect. Grants one
// master round-robin and holds the grant for a full write transaction
// (AW, W burst through WLAST, then B). Drives the AW/W mux / B demux select
// and per-channel enables that gate valid/ready through the selectors.
//   clk, rst               : clock, synchronous active-high reset
//   m_awvalid [N_M]        : per-master AWVALID requests for this slave
//   s_awvalid, s_awready   : AW handshake at the slave side
//   s_wvalid, s_wready,
//   s_wlast                : W handshake and last-beat marker
//   s_bvalid, s_bready     : B handshake at the slave side
//   sel [SEL_WIDTH]        : mux/demux select code
//   grant [N_M]            : one-hot grant, zero when idle
//   aw_en, w_en, b_en      : channel pass enables
//   busy                   : a transaction is in flight
// All outputs decode registered state only; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module axi_inter_wr_arb
    import axi_inter_pkg::*;
#(
    parameter  int SEL_WIDTH = 2,
    localparam int N_M       = n_masters(SEL_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_M-1:0]       m_awvalid,
    input  logic                 s_awvalid,
    input  logic                 s_awready,
    input  logic                 s_wvalid,
    input  logic                 s_wready,
    input  logic                 s_wlast,
    input  logic                 s_bvalid,
    input  logic                 s_bready,
    output logic [SEL_WIDTH-1:0] sel,
    output logic [N_M-1:0]       grant,
    output logic                 aw_en,
    output logic                 w_en,
    output logic                 b_en,
    output logic                 busy
);

    wr_arb_state_t        state_q,   state_d;
    logic [SEL_WIDTH-1:0] sel_q,     sel_d;
    logic [SEL_WIDTH-1:0] rr_ptr_q,  rr_ptr_d;
    logic                 aw_done_q, aw_done_d;
    logic                 w_done_q,  w_done_d;

    logic [SEL_WIDTH-1:0] pick_idx;
    logic                 pick_found;
    logic                 aw_hs;
    logic                 wlast_hs;
    logic                 b_hs;

    axi_inter_rr_pick #(
        .SEL_WIDTH (SEL_WIDTH)
    ) u_pick (
        .req   (m_awvalid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Handshakes only count while the channel is enabled, so a slave that
    // asserts BVALID early is blocked rather than consumed.
    assign aw_hs    = s_awvalid & s_awready & aw_en;
    assign wlast_hs = s_wvalid & s_wready & s_wlast & w_en;
    assign b_hs     = s_bvalid & s_bready & b_en;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            rr_ptr_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_ptr_q  <= rr_ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_ptr_d  = rr_ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        unique case (state_q)
            IDLE: begin
                // Requests are only looked at here; changes in DATA/RESP
                // cannot disturb the current grant.
                if (pick_found) begin
                    state_d = DATA;
                    sel_d   = pick_idx;
                end
            end
            DATA: begin
                if (aw_hs)    aw_done_d = 1'b1;
                if (wlast_hs) w_done_d  = 1'b1;
                // Either order, or both in one cycle, completes the request.
                if ((aw_done_q | aw_hs) && (w_done_q | wlast_hs)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (b_hs) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rr_ptr_d  = sel_q + SEL_WIDTH'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode (registered state only)
    // -----------------------------------------------------------------------
    always_comb begin
        sel   = sel_q;
        grant = '0;
        aw_en = 1'b0;
        w_en  = 1'b0;
        b_en  = 1'b0;
        busy  = 1'b0;

        unique case (state_q)
            DATA: begin
                grant = {{(N_M-1){1'b0}}, 1'b1} << sel_q;
                busy  = 1'b1;
                aw_en = ~aw_done_q;
                w_en  = ~w_done_q;
            end
            RESP: begin
                grant = {{(N_M-1){1'b0}}, 1'b1} << sel_q;
                busy  = 1'b1;
                b_en  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule : axi_inter_wr_arb
